// File: rtl/divider_constant_time.sv
`default_nettype none
// ==========================================================================
// divider_constant_time : restoring unsigned divider, fixed WIDTH-step latency
// Revision 1.0
// ==========================================================================
module divider_constant_time #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             quotientDone
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_BUSY = 2'd1;
  localparam logic [1:0]    S_DONE = 2'd2;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_s, step_t;
  logic [WIDTH-1:0] step_r, step_q;

  // Partial remainder always stays below 2^WIDTH, so its constant-zero top bit is not stored.
  always_comb begin
    step_s = {r_q, q_q[WIDTH-1]};
    step_t = step_s - {1'b0, d_q};
    step_r = step_t[WIDTH] ? step_s[WIDTH-1:0] : step_t[WIDTH-1:0];
    step_q = {q_q[WIDTH-2:0], ~step_t[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        q_d     = step_q;
        r_d     = step_r;
        count_d = count_q + CW'(1);
        if (count_q == C_LAST) begin
          quot_d  = step_q;
          rem_d   = step_r;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign busy         = busy_q;
  assign quotientDone = done_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_constant_time.sv
`default_nettype none
// ==========================================================================
// tb_divider_constant_time : dual-instance bench, vector table + random model
// Revision 1.0
// ==========================================================================
module tb_divider_constant_time;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] a_a = '0, b_a = '0, a_b = '0, b_b = '0;
  logic [W-1:0] q_a, r_a, q_b, r_b;
  logic         busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t         vecs [7];
  logic [W-1:0] ops_a [40];
  logic [W-1:0] ops_b [40];

  always #5 clk = ~clk;

  divider_constant_time #(.WIDTH(W)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dividend(a_a), .divisor(b_a),
    .quotient(q_a), .remainder(r_a), .busy(busy_a), .quotientDone(done_a)
  );

  divider_constant_time #(.WIDTH(W)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dividend(a_b), .divisor(b_b),
    .quotient(q_b), .remainder(r_b), .busy(busy_b), .quotientDone(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : W'(int'(a) % int'(b));
  endfunction

  // Starts both instances on the same edge and follows them to completion.
  task automatic run_pair(input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          output int lat, output int busyc, output bit coinc,
                          output bit idle_after);
    @(negedge clk);
    start_a = 1'b1; a_a = a0; b_a = b0;
    start_b = 1'b1; a_b = a1; b_b = b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    a_a = W'($urandom); b_a = W'($urandom); a_b = W'($urandom); b_b = W'($urandom);
    lat = 0; busyc = 0; coinc = 1'b1;
    while (!done_a && lat < 40) begin
      if (busy_a) busyc++;
      if (done_a !== done_b || busy_a !== busy_b) coinc = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done_a !== done_b) coinc = 1'b0;
    if (busy_a) busyc++;
    @(negedge clk);
    idle_after = !busy_a && !done_a && !done_b;
  endtask

  initial begin
    int  lat, busyc;
    bit  coinc, idle_after;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
    vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[3] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77};
    vecs[4] = '{a: 8'd100, b: 8'd3,   q: 8'd33,  r: 8'd1};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
    vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};

    #2 rst = 1'b0;
    #1;
    check("reset_quotient", q_a, 0);
    check("reset_remainder", r_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].b, vecs[i].a, lat, busyc, coinc, idle_after);
      check("vec_quotient", q_a, vecs[i].q);
      check("vec_remainder", r_a, vecs[i].r);
      check("vec_b_quotient", q_b, ref_q(vecs[i].b, vecs[i].a));
      check("vec_b_remainder", r_b, ref_r(vecs[i].b, vecs[i].a));
      check("vec_latency", lat, W);
      check("vec_busy_cycles", busyc, W + 1);
      check("vec_done_coincident", coinc, 1);
      check("vec_idle_after", idle_after, 1);
    end

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] x0, y0, x1, y1;
      x0 = W'($urandom);
      x1 = W'($urandom);
      y0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      y1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      run_pair(x0, y0, x1, y1, lat, busyc, coinc, idle_after);
      check("rnd_a_quotient", q_a, ref_q(x0, y0));
      check("rnd_a_remainder", r_a, ref_r(x0, y0));
      check("rnd_b_quotient", q_b, ref_q(x1, y1));
      check("rnd_b_remainder", r_b, ref_r(x1, y1));
      check("rnd_latency", lat, W);
      check("rnd_done_coincident", coinc, 1);
      if (y0 != 0) begin
        check("rnd_invariant", 32'(q_a) * 32'(y0) + 32'(r_a), 32'(x0));
        check("rnd_rem_below_divisor", 32'(r_a < y0), 1);
      end
    end

    // start held high with operands changing every cycle
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j > 0) begin
        check("hold_busy", busy_a, (j % 10) != 0);
        check("hold_done", done_a, (j % 10) == 9);
        if ((j % 10) == 9) begin
          check("hold_quotient", q_a, ref_q(ops_a[j-9], ops_b[j-9]));
          check("hold_remainder", r_a, ref_r(ops_a[j-9], ops_b[j-9]));
        end
      end
      ops_a[j] = W'($urandom);
      ops_b[j] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 40));
      a_a = ops_a[j];
      b_a = ops_b[j];
      start_a = 1'b1;
    end
    start_a = 1'b0;
    repeat (12) @(negedge clk);

    run_pair(8'd255, 8'd1, 8'd254, 8'd1, lat, busyc, coinc, idle_after);
    check("pre_rst_quotient", q_a, 255);

    // asynchronous reset in the middle of 200/7
    @(negedge clk);
    start_a = 1'b1; a_a = 8'd200; b_a = 8'd7;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_quotient", q_a, 0);
    check("midrst_remainder", r_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_b_quotient", q_b, 0);
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ignores_start", busy_a, 0);
    start_a = 1'b0;
    rst = 1'b1;
    run_pair(8'd100, 8'd3, 8'd3, 8'd100, lat, busyc, coinc, idle_after);
    check("post_rst_quotient", q_a, 33);
    check("post_rst_remainder", r_a, 1);
    check("post_rst_latency", lat, W);
    check("post_rst_coincident", coinc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
